// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS pipeline stages.
//   - Bit positions inside the 9-bit decoded control bundle
//     {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src,
//      reg_dst, alu_op[1:0]}
//   - alu_op encodings driven into the ALU control decoder
//   - Architectural register $0 index
package mips_pkg;

  localparam int CTRL_W         = 9;
  localparam int CTRL_REG_WRITE = 8;
  localparam int CTRL_MEM_TO_REG = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_ALU_SRC   = 3;
  localparam int CTRL_REG_DST   = 2;
  localparam int CTRL_ALU_OP_HI = 1;
  localparam int CTRL_ALU_OP_LO = 0;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use comparator.
// Flags when the instruction in EX is a load whose destination (rt) is
// read by the valid instruction in ID. A load into $0 never hazards.
// Ports:
//   id_valid     in   ID holds a real instruction
//   id_rs/id_rt  in   ID source registers
//   id_uses_rt   in   ID instruction reads rt as a source
//   ex_valid     in   EX holds a real instruction
//   ex_mem_read  in   EX instruction is a load
//   ex_rt        in   EX load destination
//   hazard       out  load-use hazard present
module hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              hazard
);

  logic ex_load_live;
  logic rs_match;
  logic rt_match;

  always_comb begin
    ex_load_live = ex_valid && ex_mem_read && (ex_rt != REG_AW'(REG_ZERO));
    rs_match     = (ex_rt == id_rs);
    rt_match     = id_uses_rt && (ex_rt == id_rt);
    hazard       = id_valid && ex_load_live && (rs_match || rt_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and flush.
// Captures register-file read data, decoded control, immediate and PC+4
// into the EX-stage register one cycle after ID. A load-use hazard
// holds PC and IF/ID (stall) and sends a bubble into EX; a flush kills
// the ID instruction and takes priority over a stall.
// Ports:
//   clk, rst                 clock, async active-low reset
//   id_valid .. id_ctrl      ID-stage instruction fields
//   read_data1/2             register file read ports
//   flush                    kill the ID instruction this cycle
//   stall                    hold PC and IF/ID (combinational)
//   ex_*                     registered EX-stage fields
//   ex_wreg                  EX destination register (rd or rt)
//   stall_cnt                saturating count of stall cycles
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_AW-1:0] ex_wreg,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic hazard;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
    .ex_rt       (ex_rt),
    .hazard      (hazard)
  );

  // A flush already discards the ID instruction, so holding IF/ID for it
  // would only re-present a killed instruction.
  assign stall = hazard && !flush;

  assign ex_wreg = ex_ctrl[CTRL_REG_DST] ? ex_rd : ex_rt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_imm    <= '0;
      ex_pc4    <= '0;
      ex_ctrl   <= '0;
      stall_cnt <= '0;
    end else if (flush || stall) begin
      // Bubble: zero control guarantees no write/load/store downstream.
      ex_valid <= 1'b0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_pc4   <= '0;
      ex_ctrl  <= '0;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end else begin
      ex_valid <= id_valid;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_a     <= read_data1;
      ex_b     <= read_data2;
      ex_imm   <= id_imm;
      ex_pc4   <= id_pc4;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam logic [8:0] C_LW   = 9'b111001000;
  localparam logic [8:0] C_RADD = 9'b100000110;
  localparam logic [8:0] C_ADDI = 9'b100001000;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [31:0] read_data1, read_data2, id_imm, id_pc4;
  logic [8:0]  id_ctrl;
  logic        flush;

  logic        stall, ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_wreg;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
  logic [8:0]  ex_ctrl;
  logic [15:0] stall_cnt;

  logic        s_stall, s_ex_valid;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd, s_ex_wreg;
  logic [31:0] s_ex_a, s_ex_b, s_ex_imm, s_ex_pc4;
  logic [8:0]  s_ex_ctrl;
  logic [1:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm, pc4;
    logic [8:0]  ctrl;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
  } ex_t;

  ex_t m;
  ex_t sb_q[$];

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .read_data1(read_data1),
    .read_data2(read_data2), .id_imm(id_imm), .id_pc4(id_pc4), .id_ctrl(id_ctrl),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_pc4(ex_pc4), .ex_ctrl(ex_ctrl), .ex_wreg(ex_wreg), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .read_data1(read_data1),
    .read_data2(read_data2), .id_imm(id_imm), .id_pc4(id_pc4), .id_ctrl(id_ctrl),
    .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid), .ex_rs(s_ex_rs),
    .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_a(s_ex_a), .ex_b(s_ex_b),
    .ex_imm(s_ex_imm), .ex_pc4(s_ex_pc4), .ex_ctrl(s_ex_ctrl),
    .ex_wreg(s_ex_wreg), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ex_t zero_ex();
    ex_t z;
    z.valid = 1'b0; z.rs = '0; z.rt = '0; z.rd = '0;
    z.a = '0; z.b = '0; z.imm = '0; z.pc4 = '0; z.ctrl = '0;
    z.cnt = '0; z.cnt_s = '0;
    return z;
  endfunction

  task automatic check_ex(input ex_t e);
    chk("ex_valid", ex_valid, e.valid);
    chk("ex_rs", ex_rs, e.rs);
    chk("ex_rt", ex_rt, e.rt);
    chk("ex_rd", ex_rd, e.rd);
    chk("ex_a", ex_a, e.a);
    chk("ex_b", ex_b, e.b);
    chk("ex_imm", ex_imm, e.imm);
    chk("ex_pc4", ex_pc4, e.pc4);
    chk("ex_ctrl", ex_ctrl, e.ctrl);
    chk("ex_wreg", ex_wreg, e.ctrl[2] ? e.rd : e.rt);
    chk("stall_cnt", stall_cnt, e.cnt);
    chk("sat_stall_cnt", s_stall_cnt, e.cnt_s);
    chk("sat_ex_ctrl", s_ex_ctrl, e.ctrl);
  endtask

  // Called right after a negedge: drive ID, check stall, push expected
  // EX contents, clock, then pop and compare.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic ur,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] imm, input logic [31:0] pc4,
                      input logic [8:0] c, input logic fl);
    logic haz, exp_stall;
    ex_t nx, got;
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ur;
    read_data1 = d1; read_data2 = d2; id_imm = imm; id_pc4 = pc4;
    id_ctrl = c; flush = fl;
    #1;
    haz = v && m.valid && m.ctrl[6] && (m.rt != 5'd0) &&
          ((m.rt == rs) || (ur && (m.rt == rt)));
    exp_stall = haz && !fl;
    chk("stall", stall, exp_stall);
    chk("sat_stall", s_stall, exp_stall);
    nx = m;
    if (fl || exp_stall) begin
      nx.valid = 1'b0; nx.rs = '0; nx.rt = '0; nx.rd = '0;
      nx.a = '0; nx.b = '0; nx.imm = '0; nx.pc4 = '0; nx.ctrl = '0;
      if (exp_stall) begin
        if (m.cnt != 16'hFFFF) nx.cnt = m.cnt + 16'd1;
        if (m.cnt_s != 2'd3) nx.cnt_s = m.cnt_s + 2'd1;
      end
    end else begin
      nx.valid = v; nx.rs = rs; nx.rt = rt; nx.rd = rd;
      nx.a = d1; nx.b = d2; nx.imm = imm; nx.pc4 = pc4;
      nx.ctrl = v ? c : 9'd0;
    end
    sb_q.push_back(nx);
    m = nx;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = sb_q.pop_front();
      check_ex(got);
    end
    @(negedge clk);
  endtask

  initial begin
    m = zero_ex();
    rst = 1'b0;
    flush = 1'b0;
    // Random inputs while in reset, including a load-use-looking pattern.
    id_valid = 1'b1; id_rs = 5'd2; id_rt = 5'd2; id_rd = 5'($urandom);
    id_uses_rt = 1'b1; read_data1 = $urandom; read_data2 = $urandom;
    id_imm = $urandom; id_pc4 = $urandom; id_ctrl = C_LW;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    check_ex(zero_ex());
    rst = 1'b1;
    @(negedge clk);

    // lw $2,0($1) captured on first edge after reset
    step(1, 5'd1, 5'd2, 5'd0, 0, 32'h100, 32'h200, 32'h0, 32'h4, C_LW, 0);
    // add $3,$2,$4: load-use stall, then re-presented with WB data
    step(1, 5'd2, 5'd4, 5'd3, 1, 32'h22, 32'h44, 32'h0, 32'h8, C_RADD, 0);
    step(1, 5'd2, 5'd4, 5'd3, 1, 32'h222, 32'h44, 32'h0, 32'h8, C_RADD, 0);

    // lw $0 then an instruction reading $0: no stall
    step(1, 5'd1, 5'd0, 5'd0, 0, 32'h10, 32'h0, 32'h8, 32'hC, C_LW, 0);
    step(1, 5'd0, 5'd0, 5'd9, 1, 32'h0, 32'h0, 32'h0, 32'h10, C_RADD, 0);

    // lw $5, addi $6,$5 (rs match, rt not a source)
    step(1, 5'd1, 5'd5, 5'd0, 0, 32'h30, 32'h0, 32'h4, 32'h14, C_LW, 0);
    step(1, 5'd5, 5'd6, 5'd0, 0, 32'h55, 32'h66, 32'h7, 32'h18, C_ADDI, 0);
    step(1, 5'd5, 5'd6, 5'd0, 0, 32'h555, 32'h66, 32'h7, 32'h18, C_ADDI, 0);
    // lw $5, then rt=5 but not used as source: no stall
    step(1, 5'd1, 5'd5, 5'd0, 0, 32'h30, 32'h0, 32'h4, 32'h1C, C_LW, 0);
    step(1, 5'd7, 5'd5, 5'd0, 0, 32'h77, 32'h55, 32'h9, 32'h20, C_ADDI, 0);
    // lw $5, then rt=5 used as source: stall
    step(1, 5'd1, 5'd5, 5'd0, 0, 32'h30, 32'h0, 32'h4, 32'h24, C_LW, 0);
    step(1, 5'd7, 5'd5, 5'd8, 1, 32'h77, 32'h55, 32'h0, 32'h28, C_RADD, 0);
    step(1, 5'd7, 5'd5, 5'd8, 1, 32'h77, 32'h5A5, 32'h0, 32'h28, C_RADD, 0);

    // Flush while the hazard condition holds: no stall, bubble, count held
    step(1, 5'd1, 5'd5, 5'd0, 0, 32'h30, 32'h0, 32'h4, 32'h2C, C_LW, 0);
    step(1, 5'd5, 5'd6, 5'd0, 0, 32'h55, 32'h66, 32'h7, 32'h30, C_ADDI, 1);

    // Invalid ID slot: fields captured, control zeroed
    step(0, 5'd3, 5'd4, 5'd5, 1, 32'hAA, 32'hBB, 32'hCC, 32'h34, C_RADD, 0);

    // Back-to-back lw $2,0($2): alternates stall/capture, drives saturation
    repeat (10) step(1, 5'd2, 5'd2, 5'd0, 0, 32'h1234, 32'h0, 32'h0, 32'h38, C_LW, 0);
    chk("sat_at_max", s_stall_cnt, 2'd3);

    // Reset asserted mid-stall cancels the stall immediately
    step(1, 5'd1, 5'd2, 5'd0, 0, 32'h100, 32'h0, 32'h0, 32'h3C, C_LW, 0);
    id_valid = 1'b1; id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
    id_ctrl = C_RADD; flush = 1'b0;
    #1;
    chk("pre_rst_stall", stall, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_valid", ex_valid, 1'b0);
    chk("mid_rst_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    m = zero_ex();
    sb_q.delete();
    step(1, 5'd9, 5'd10, 5'd11, 1, 32'hDEAD, 32'hBEEF, 32'h1, 32'h40, C_RADD, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS datapath, directly downstream of the register file.
- Captures the register file read ports, the decoded control bits and the immediate into the EX-stage register.
- Contains load-use hazard detection: on a hazard it stalls PC and IF/ID and inserts a bubble.
- Also accepts branch flushes, and keeps a saturating stall counter for debug.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_rs  in  REG_AW  source register 1 (drives regFile read_reg1)
id_rt  in  REG_AW  source register 2 (drives regFile read_reg2)
id_rd  in  REG_AW  R-type destination
id_uses_rt  in  1  instruction reads rt as a source (R-type, beq, sw)
read_data1  in  DATA_W  regFile port 1
read_data2  in  DATA_W  regFile port 2
id_imm  in  DATA_W  sign-extended immediate
id_pc4  in  DATA_W  PC+4
id_ctrl  in  9  {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[1:0]}
flush  in  1  branch taken / redirect; kill the ID instruction
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX holds a real instruction
ex_rs, ex_rt, ex_rd  out  REG_AW each  registered addresses
ex_a, ex_b  out  DATA_W each  registered read_data1 / read_data2
ex_imm, ex_pc4  out  DATA_W each  registered
ex_ctrl  out  9  registered control bundle
ex_wreg  out  REG_AW  destination: ex_rd if reg_dst, else ex_rt
stall_cnt  out  CNT_W  number of hazard stall cycles since reset

Behaviour:
- Reset (rst=0, async): all ex_* outputs = 0, ex_valid = 0, stall_cnt = 0. stall is 0 while ex_valid is 0.
- Hazard detection (combinational):
  - hazard = id_valid & ex_valid & ex_ctrl.mem_read & ex_rt != 0 & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt)).
  - stall = hazard & ~flush.
- Posedge update, evaluated in priority order:
  1. flush=1: bubble. ex_valid <= 0, ex_ctrl <= 0, data and address fields <= 0. A flush overrides stall.
  2. stall=1: bubble with the same clearing rules. stall_cnt increments and saturates at all-ones.
  3. Otherwise: capture all id_* inputs and read_data1/2. ex_valid <= id_valid. If id_valid=0, ex_ctrl <= 0.
- Latency: one cycle from ID inputs to ex_* outputs.
- Stall duration:
  - A load-use hazard stalls exactly one cycle, because the load then leaves EX and the bubble's mem_read is 0.
  - The ID instruction is presented again on the next cycle and captured.
- Register file timing: regFile writes on negedge, so a WB write is visible in the same cycle's read_data. This stage has no WB→ID bypass.
- Register $0: a load targeting $0 never causes a stall.
- ex_wreg is combinational from registered ex_rd, ex_rt and ex_ctrl.reg_dst.
- A bubble must never assert reg_write, mem_read or mem_write downstream.
- Reset asserted mid-stall: the stall is cancelled immediately, because stall depends on ex_valid, which is forced to 0.

Decomposition:
- Shared package mips_pkg holds:
  - ctrl bundle bit-index constants (CTRL_REG_WRITE=8 … CTRL_ALU_OP=1:0) and width CTRL_W=9;
  - alu_op encodings: 00 add, 01 sub, 10 funct;
  - REG_ZERO=0.
- Sub-module hazard_detect: a purely combinational load-use comparator producing hazard.

Test Plan:
- Reset: hold rst=0 with random inputs → all ex_* = 0, stall=0, stall_cnt=0. Release rst → first posedge captures id_* values.
- Load-use: lw $2,0($1) in EX, then add $3,$2,$4 in ID → stall=1 for 1 cycle, EX bubble with ex_ctrl=0, stall_cnt=1. Next cycle: ex_a=read_data1 of $2, ex_valid=1.
- No hazard on $0: lw $0 in EX, ID reads $0 → stall=0, capture proceeds.
- rt not a source: lw $5 in EX, ID addi $6,$5 with id_uses_rt=0 and id_rs=5 → stall (match on rs). Same with id_rs=7, id_rt=5 → no stall.
- Flush during hazard: hazard condition true and flush=1 → stall=0, bubble, stall_cnt unchanged.
- Saturation: with CNT_W=2, force 5 hazard cycles → stall_cnt stays at 3.
